// File: rtl/reg_bank.sv
// Multi-port register bank: one write port, two registered read ports with
// write-first bypass and an optional hardwired-zero register 0.
module reg_bank #(
    parameter int unsigned width     = 8,
    parameter int unsigned addr_bits = 2,
    parameter bit          zero_r0   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [addr_bits-1:0] waddr,
    input  logic [width-1:0]     wdata,
    input  logic                 re,
    input  logic [addr_bits-1:0] raddr_a,
    input  logic [addr_bits-1:0] raddr_b,
    output logic [width-1:0]     rdata_a,
    output logic [width-1:0]     rdata_b,
    output logic                 rvalid
);

    localparam int unsigned depth = 2 ** addr_bits;

    logic [width-1:0] regs_q [depth];
    logic [width-1:0] regs_d [depth];
    logic [width-1:0] rdata_a_q, rdata_a_d;
    logic [width-1:0] rdata_b_q, rdata_b_d;
    logic             rvalid_q;

    // regs_d is the post-write view of the bank; reading from it gives the
    // write-first bypass and the forced-zero register 0 for free.
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
        if (zero_r0) begin
            regs_d[0] = '0;
        end
    end

    always_comb begin
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        if (re) begin
            rdata_a_d = regs_d[raddr_a];
            rdata_b_d = regs_d[raddr_b];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q    <= '{default: '0};
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            rvalid_q  <= re;
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
    assign rvalid  = rvalid_q;

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: directed scenarios then random traffic, two instances
// (register 0 hardwired to zero, and a plain register 0) sharing all inputs.
module tb_reg_bank;

    logic       clk;
    logic       rst;
    logic       we;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic       re;
    logic [1:0] raddr_a;
    logic [1:0] raddr_b;
    logic [7:0] rdata_a_z, rdata_b_z, rdata_a_n, rdata_b_n;
    logic       rvalid_z, rvalid_n;

    int checks = 0;
    int errors = 0;

    reg_bank #(.width(8), .addr_bits(2), .zero_r0(1'b1)) u_dut_z (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rdata_a_z), .rdata_b(rdata_b_z), .rvalid(rvalid_z)
    );

    reg_bank #(.width(8), .addr_bits(2), .zero_r0(1'b0)) u_dut_n (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rdata_a_n), .rdata_b(rdata_b_n), .rvalid(rvalid_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain memories plus the expected output registers.
    logic [7:0] mem_z [4];
    logic [7:0] mem_n [4];
    logic [7:0] exp_a_z, exp_b_z, exp_a_n, exp_b_n;
    logic       exp_v;

    function automatic logic [7:0] mdl_read(input bit zero_mode, input logic [1:0] addr);
        if (zero_mode && addr == 2'd0) return 8'h00;
        if (we && addr == waddr) return wdata;
        return zero_mode ? mem_z[addr] : mem_n[addr];
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 4; i++) begin
            mem_z[i] = 8'h00;
            mem_n[i] = 8'h00;
        end
        exp_a_z = 8'h00; exp_b_z = 8'h00;
        exp_a_n = 8'h00; exp_b_n = 8'h00;
        exp_v = 1'b0;
    endtask

    task automatic mdl_edge();
        if (re) begin
            exp_a_z = mdl_read(1'b1, raddr_a);
            exp_b_z = mdl_read(1'b1, raddr_b);
            exp_a_n = mdl_read(1'b0, raddr_a);
            exp_b_n = mdl_read(1'b0, raddr_b);
        end
        exp_v = re;
        if (we) begin
            if (waddr != 2'd0) mem_z[waddr] = wdata;
            mem_n[waddr] = wdata;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".a_z"}, rdata_a_z, exp_a_z);
        check({tag, ".b_z"}, rdata_b_z, exp_b_z);
        check({tag, ".v_z"}, {7'd0, rvalid_z}, {7'd0, exp_v});
        check({tag, ".a_n"}, rdata_a_n, exp_a_n);
        check({tag, ".b_n"}, rdata_b_n, exp_b_n);
        check({tag, ".v_n"}, {7'd0, rvalid_n}, {7'd0, exp_v});
    endtask

    // One clock edge: model and DUT both act on the inputs now applied.
    task automatic step(input string tag);
        @(posedge clk);
        mdl_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic w, input logic [1:0] wa, input logic [7:0] wd,
                         input logic r, input logic [1:0] ra, input logic [1:0] rb);
        we = w; waddr = wa; wdata = wd; re = r; raddr_a = ra; raddr_b = rb;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0);
        mdl_reset();
        #3;
        check_all("reset_init");
        @(negedge clk);
        rst = 1'b1;

        // Mid-cycle reset discards pending traffic and clears everything.
        drive(1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 2'd0);
        step("wr_r2");
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd2);
        step("rd_r2");
        check("rd_r2_lit", rdata_a_z, 8'hA5);
        drive(1'b1, 2'd3, 8'hEE, 1'b1, 2'd2, 2'd3);
        #2;
        rst = 1'b0;
        #1;
        mdl_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        #2;
        rst = 1'b1;
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd3);
        step("rd_after_rst");
        check("rd_after_rst_lit", rdata_a_z, 8'h00);

        // Basic write then dual read.
        drive(1'b1, 2'd1, 8'h3C, 1'b0, 2'd0, 2'd0);
        step("wr_r1");
        drive(1'b1, 2'd3, 8'hC3, 1'b0, 2'd0, 2'd0);
        step("wr_r3");
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd3);
        step("rd_13");
        check("rd_13_a", rdata_a_z, 8'h3C);
        check("rd_13_b", rdata_b_z, 8'hC3);
        check("rd_13_v", {7'd0, rvalid_z}, 8'h01);

        // Hold while re low, even as r1 is rewritten.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd1, 8'h77, 1'b0, 2'd1, 2'd1);
            step("hold");
            check("hold_a", rdata_a_z, 8'h3C);
            check("hold_v", {7'd0, rvalid_z}, 8'h00);
        end
        drive(1'b1, 2'd1, 8'h3C, 1'b0, 2'd0, 2'd0);
        step("restore_r1");

        // Write-first bypass.
        drive(1'b1, 2'd2, 8'h5A, 1'b1, 2'd2, 2'd1);
        step("bypass");
        check("bypass_a", rdata_a_z, 8'h5A);
        check("bypass_b", rdata_b_z, 8'h3C);

        // Register 0 behaviour in both modes.
        drive(1'b1, 2'd0, 8'hFF, 1'b1, 2'd0, 2'd0);
        step("r0_same_edge");
        check("r0_same_z", rdata_a_z, 8'h00);
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd0);
        step("r0_later");
        check("r0_later_z", rdata_b_z, 8'h00);
        check("r0_later_n", rdata_a_n, 8'hFF);

        // Streaming reads.
        drive(1'b1, 2'd1, 8'h11, 1'b0, 2'd0, 2'd0); step("wr_s1");
        drive(1'b1, 2'd2, 8'h22, 1'b0, 2'd0, 2'd0); step("wr_s2");
        drive(1'b1, 2'd3, 8'h33, 1'b0, 2'd0, 2'd0); step("wr_s3");
        for (int i = 0; i < 4; i++) begin
            logic [7:0] want;
            drive(1'b0, 2'd0, 8'h00, 1'b1, 2'(i), 2'(3 - i));
            step("stream");
            want = 8'(i * 8'h11);
            check("stream_a", rdata_a_z, want);
            check("stream_v", {7'd0, rvalid_z}, 8'h01);
        end
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0);
        step("stream_end");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom),
                  2'($urandom), 2'($urandom));
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter `width`, default 8, SHALL set the data bit width of every register and data port.
REQ-002 Parameter `addr_bits`, default 2, SHALL set the address width; the bank holds 2^addr_bits registers.
REQ-003 Parameter `zero_r0`, default 1, SHALL, when 1, hardwire register 0 to all-zeros (writes ignored).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 we  input  1  write enable, sampled at rising clk.
REQ-007 waddr  input  addr_bits  write address.
REQ-008 wdata  input  width  write data.
REQ-009 re  input  1  read request, sampled at rising clk.
REQ-010 raddr_a  input  addr_bits  read port A address.
REQ-011 raddr_b  input  addr_bits  read port B address.
REQ-012 rdata_a  output  width  registered read data, port A.
REQ-013 rdata_b  output  width  registered read data, port B.
REQ-014 rvalid  output  1  high for exactly one cycle per accepted read.

Function
REQ-015 At a rising clk with rst high and we high, register[waddr] SHALL take wdata, except waddr==0 when zero_r0==1.
REQ-016 At a rising clk with rst high and re high, rdata_a/rdata_b SHALL load register[raddr_a]/register[raddr_b]; read latency is 1 cycle.
REQ-017 rvalid SHALL be the value of re registered at the preceding rising clk (1 cycle later, 1 cycle wide per request).
REQ-018 With re low, rdata_a/rdata_b SHALL hold their previous values.
REQ-019 Read-during-write: if re and we are both high on the same edge and raddr_x==waddr, rdata_x SHALL load wdata (write-first bypass), unless waddr==0 with zero_r0==1, in which case rdata_x SHALL load 0.
REQ-020 Read of address 0 with zero_r0==1 SHALL return 0 regardless of write history.
REQ-021 Both read ports SHALL be independent; raddr_a==raddr_b SHALL return identical data on both ports.
REQ-022 Back-to-back re on consecutive cycles SHALL give rvalid high on consecutive cycles, each with the data of its own request; no throughput limit.
REQ-023 Back-to-back writes to the same address SHALL leave the later wdata stored.
REQ-024 Address arithmetic SHALL be unsigned, exactly addr_bits wide; no out-of-range addresses exist.
REQ-025 Read muxing SHALL be a binary select tree over 2^addr_bits entries; no latches, no tristate or inout ports.

Reset
REQ-026 While rst is low, all registers, rdata_a, rdata_b and rvalid SHALL be 0, asserted immediately without waiting for clk.
REQ-027 A read or write in flight when rst falls SHALL be discarded; rvalid SHALL not pulse for it.
REQ-028 The first rising clk after rst rises SHALL be a normal operating edge (we/re honoured).
REQ-029 Reset deassertion is synchronised externally; the block SHALL need no internal reset synchroniser.

Verification
REQ-030 Reset: drive rst low mid-cycle after writing 0xA5 to r2 -> rdata_a, rdata_b, rvalid go to 0 before the next edge; later read of r2 -> 0x00.
REQ-031 Write/read: write 0x3C to r1, 0xC3 to r3; next cycle re with raddr_a=1, raddr_b=3 -> one cycle later rdata_a=0x3C, rdata_b=0xC3, rvalid=1 for one cycle.
REQ-032 Bypass: same edge we=1, waddr=2, wdata=0x5A, re=1, raddr_a=2, raddr_b=1 (r1=0x3C) -> rdata_a=0x5A, rdata_b=0x3C.
REQ-033 Zero register: write 0xFF to r0 with zero_r0=1, same-edge read of r0 on both ports, then a later read -> 0x00 each time; with zero_r0=0 -> 0xFF on the later read.
REQ-034 Streaming: re held high 4 cycles, raddr_a stepping 0,1,2,3 with r1..r3=0x11,0x22,0x33 -> rvalid high 4 consecutive cycles, rdata_a=0x00,0x11,0x22,0x33.
REQ-035 Hold: re low for 3 cycles after REQ-031 while writing 0x77 to r1 -> rdata_a stays 0x3C, rvalid stays 0.
